exec_stage: RTL and testbench

EXEC_STAGE -- requirements
Module: exec_stage

---
 rtl/exec_pkg.sv | 36 +++
 rtl/mul_iter.sv | 57 +++++
 rtl/exec_stage.sv | 170 +++++++++++++++++
 tb/tb_exec_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared widths, opcode map and state encoding for the execute stage.
package exec_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned OP_W      = 6;
  localparam int unsigned MUL_ITERS = 32;
  localparam int unsigned CNT_W     = 6;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 6'h00,
    OP_ADD  = 6'h01,
    OP_SUB  = 6'h02,
    OP_AND  = 6'h03,
    OP_OR   = 6'h04,
    OP_XOR  = 6'h05,
    OP_LDI  = 6'h06,
    OP_ADDI = 6'h07,
    OP_SHL  = 6'h08,
    OP_SHR  = 6'h09,
    OP_MUL  = 6'h0A
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_WB
  } state_e;

  function automatic logic is_mul(input logic [OP_W-1:0] op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative 32x32 shift-add multiplier returning the low 32 product bits.
module mul_iter
  import exec_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // The load edge performs iteration 0 so 32 iterations end one edge before write-back.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start_i && cnt_q == '0) begin
      acc_d    = b_i[0] ? a_i : '0;
      mcand_d  = a_i << 1;
      mplier_d = b_i >> 1;
      cnt_d    = CNT_W'(MUL_ITERS - 1);
    end else if (cnt_q != '0) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy_o    = cnt_q != '0;
  assign done_o    = cnt_q == CNT_W'(1);
  assign product_o = acc_q;

endmodule

// File: rtl/exec_stage.sv
// Execute stage: register file, single-cycle ALU and iterative multiply with write-back.
module exec_stage
  import exec_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              regEn,
  input  logic [OP_W-1:0]   opcode,
  input  logic [REG_AW-1:0] oppA,
  input  logic [REG_AW-1:0] oppB,
  input  logic [DATA_W-1:0] literal,
  output logic              busy,
  output logic [DATA_W-1:0] result,
  output logic              resValid,
  output logic              zero,
  output logic              carry,
  output logic              illegal,
  input  logic [REG_AW-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData
);

  state_e state_q, state_d;

  logic [OP_W-1:0]   op_q;
  logic [REG_AW-1:0] opa_q, opb_q;
  logic [DATA_W-1:0] lit_q;
  logic [DATA_W-1:0] rf_q [NUM_REGS];

  logic [DATA_W-1:0] result_q;
  logic              resvalid_q, zero_q, carry_q, illegal_q;

  logic [DATA_W-1:0] a_val, b_val;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry, alu_wr, alu_setc, alu_bad;

  logic              accept;
  logic              wr_en, set_carry, illegal_d, mul_start;
  logic [DATA_W-1:0] wr_data;

  logic              mul_busy, mul_done;
  logic [DATA_W-1:0] mul_prod;

  assign a_val = (opa_q == '0) ? '0 : rf_q[opa_q];
  assign b_val = (opb_q == '0) ? '0 : rf_q[opb_q];

  mul_iter u_mul (
    .clk_i     (clk),
    .rst_i     (reset),
    .start_i   (mul_start),
    .a_i       (a_val),
    .b_i       (b_val),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_wr    = 1'b0;
    alu_setc  = 1'b0;
    alu_bad   = 1'b0;
    case (op_q)
      OP_NOP: ;
      OP_ADD: begin
        {alu_carry, alu_res} = {1'b0, a_val} + {1'b0, b_val};
        alu_wr   = 1'b1;
        alu_setc = 1'b1;
      end
      OP_SUB: begin
        alu_res   = a_val - b_val;
        alu_carry = a_val < b_val;
        alu_wr    = 1'b1;
        alu_setc  = 1'b1;
      end
      OP_AND: begin alu_res = a_val & b_val; alu_wr = 1'b1; end
      OP_OR:  begin alu_res = a_val | b_val; alu_wr = 1'b1; end
      OP_XOR: begin alu_res = a_val ^ b_val; alu_wr = 1'b1; end
      OP_LDI: begin alu_res = lit_q;         alu_wr = 1'b1; end
      OP_ADDI: begin
        {alu_carry, alu_res} = {1'b0, a_val} + {1'b0, lit_q};
        alu_wr   = 1'b1;
        alu_setc = 1'b1;
      end
      OP_SHL: begin alu_res = a_val << b_val[4:0]; alu_wr = 1'b1; end
      OP_SHR: begin alu_res = a_val >> b_val[4:0]; alu_wr = 1'b1; end
      OP_MUL: ;
      default: alu_bad = 1'b1;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_EXEC: begin
        if (regEn) state_d = is_mul(opcode) ? S_MUL : S_EXEC;
        else       state_d = S_IDLE;
      end
      S_MUL:   if (mul_done) state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy      = (state_q == S_MUL) || (state_q == S_WB);
    accept    = regEn && !busy;
    mul_start = (state_q == S_MUL) && !mul_busy;
    wr_en     = ((state_q == S_EXEC) && alu_wr) || (state_q == S_WB);
    wr_data   = (state_q == S_WB) ? mul_prod : alu_res;
    set_carry = (state_q == S_EXEC) && alu_setc;
    illegal_d = (state_q == S_EXEC) && alu_bad;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= '0;
      opa_q <= '0;
      opb_q <= '0;
      lit_q <= '0;
    end else if (accept) begin
      op_q  <= opcode;
      opa_q <= oppA;
      opb_q <= oppB;
      lit_q <= literal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      result_q   <= '0;
      resvalid_q <= 1'b0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      resvalid_q <= wr_en;
      illegal_q  <= illegal_d;
      if (wr_en) begin
        if (opa_q != '0) rf_q[opa_q] <= wr_data;
        result_q <= wr_data;
        zero_q   <= wr_data == '0;
      end
      if (set_carry) carry_q <= alu_carry;
    end
  end

  // Same-cycle write data bypasses the array so debug reads see the value being written.
  always_comb begin
    if (rdAddr == '0)                     rdData = '0;
    else if (wr_en && (opa_q == rdAddr))  rdData = wr_data;
    else                                  rdData = rf_q[rdAddr];
  end

  assign result   = result_q;
  assign resValid = resvalid_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_exec_stage.sv
// Directed self-checking bench for exec_stage.
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        regEn;
  logic [5:0]  opcode;
  logic [4:0]  oppA, oppB;
  logic [31:0] literal;
  logic        busy;
  logic [31:0] result;
  logic        resValid, zero, carry, illegal;
  logic [4:0]  rdAddr;
  logic [31:0] rdData;

  int n_cmp  = 0;
  int n_fail = 0;

  exec_stage dut (
    .clk      (clk),
    .reset    (reset),
    .regEn    (regEn),
    .opcode   (opcode),
    .oppA     (oppA),
    .oppB     (oppB),
    .literal  (literal),
    .busy     (busy),
    .result   (result),
    .resValid (resValid),
    .zero     (zero),
    .carry    (carry),
    .illegal  (illegal),
    .rdAddr   (rdAddr),
    .rdData   (rdData)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
                       input logic [31:0] lit);
    regEn   = 1'b1;
    opcode  = op;
    oppA    = a;
    oppB    = b;
    literal = lit;
  endtask

  task automatic peek(input logic [4:0] addr);
    rdAddr = addr;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [5:0]  t_op  [8];
  logic [4:0]  t_a   [8];
  logic [4:0]  t_b   [8];
  logic [31:0] t_lit [8];
  logic [31:0] t_exp [8];
  int          n;
  logic        flag;

  initial begin
    reset = 1'b1; regEn = 1'b0; opcode = '0; oppA = '0; oppB = '0; literal = '0; rdAddr = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_resValid", 32'(resValid), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    peek(5'd1);
    chk("rst_r1", rdData, 32'd0);

    // LDI r1,5 ; LDI r2,7 ; ADD r1,r2 back-to-back
    issue(6'h06, 5'd1, 5'd0, 32'd5); tick();
    chk("b2b_rv0", 32'(resValid), 32'd0);
    issue(6'h06, 5'd2, 5'd0, 32'd7); tick();
    chk("b2b_rv1", 32'(resValid), 32'd1);
    chk("b2b_res1", result, 32'd5);
    issue(6'h01, 5'd1, 5'd2, 32'd0); tick();
    chk("b2b_rv2", 32'(resValid), 32'd1);
    chk("b2b_res2", result, 32'd7);
    regEn = 1'b0; tick();
    chk("b2b_rv3", 32'(resValid), 32'd1);
    chk("b2b_res3", result, 32'd12);
    chk("b2b_carry", 32'(carry), 32'd0);
    peek(5'd1);
    chk("b2b_r1", rdData, 32'd12);
    tick();
    chk("b2b_rv_end", 32'(resValid), 32'd0);

    // Logic and shift ops issued back-to-back
    t_op[0] = 6'h06; t_a[0] = 5'd8;  t_b[0] = 5'd0;  t_lit[0] = 32'h0000F0F0; t_exp[0] = 32'h0000F0F0;
    t_op[1] = 6'h06; t_a[1] = 5'd9;  t_b[1] = 5'd0;  t_lit[1] = 32'h00000FF0; t_exp[1] = 32'h00000FF0;
    t_op[2] = 6'h06; t_a[2] = 5'd11; t_b[2] = 5'd0;  t_lit[2] = 32'd4;        t_exp[2] = 32'd4;
    t_op[3] = 6'h05; t_a[3] = 5'd8;  t_b[3] = 5'd9;  t_lit[3] = 32'd0;        t_exp[3] = 32'h0000FF00;
    t_op[4] = 6'h04; t_a[4] = 5'd9;  t_b[4] = 5'd8;  t_lit[4] = 32'd0;        t_exp[4] = 32'h0000FFF0;
    t_op[5] = 6'h03; t_a[5] = 5'd9;  t_b[5] = 5'd11; t_lit[5] = 32'd0;        t_exp[5] = 32'd0;
    t_op[6] = 6'h09; t_a[6] = 5'd8;  t_b[6] = 5'd11; t_lit[6] = 32'd0;        t_exp[6] = 32'h00000FF0;
    t_op[7] = 6'h08; t_a[7] = 5'd11; t_b[7] = 5'd11; t_lit[7] = 32'd0;        t_exp[7] = 32'h00000040;
    for (int k = 0; k < 8; k++) begin
      issue(t_op[k], t_a[k], t_b[k], t_lit[k]); tick();
      if (k > 0) begin
        chk("logic_res", result, t_exp[k-1]);
        chk("logic_zero", 32'(zero), 32'(t_exp[k-1] == 32'd0));
      end
    end
    regEn = 1'b0; tick();
    chk("shl_res", result, t_exp[7]);
    chk("logic_carry_hold", 32'(carry), 32'd0);

    // SUB r6,r7 with 1-2
    issue(6'h06, 5'd6, 5'd0, 32'd1); tick();
    issue(6'h06, 5'd7, 5'd0, 32'd2); tick();
    issue(6'h02, 5'd6, 5'd7, 32'd0); tick();
    regEn = 1'b0; tick();
    chk("sub_res", result, 32'hFFFFFFFF);
    chk("sub_carry", 32'(carry), 32'd1);
    chk("sub_zero", 32'(zero), 32'd0);

    // ADD r1,r2 = 19 clears carry, then LDI holds it, ADDI wraps
    issue(6'h01, 5'd1, 5'd2, 32'd0); tick();
    issue(6'h06, 5'd3, 5'd0, 32'hFFFFFFFF); tick();
    chk("add_res", result, 32'd19);
    chk("add_carry", 32'(carry), 32'd0);
    issue(6'h07, 5'd3, 5'd0, 32'd1); tick();
    chk("ldi_carry_hold", 32'(carry), 32'd0);
    regEn = 1'b0; tick();
    chk("addi_res", result, 32'd0);
    chk("addi_zero", 32'(zero), 32'd1);
    chk("addi_carry", 32'(carry), 32'd1);

    // NOP: no write-back, flags unchanged
    issue(6'h00, 5'd1, 5'd2, 32'd0); tick();
    regEn = 1'b0; tick();
    chk("nop_rv", 32'(resValid), 32'd0);
    chk("nop_zero", 32'(zero), 32'd1);
    chk("nop_carry", 32'(carry), 32'd1);
    peek(5'd1);
    chk("nop_r1", rdData, 32'd19);

    // Write-through on debug read port
    issue(6'h06, 5'd12, 5'd0, 32'h55); tick();
    regEn = 1'b0;
    peek(5'd12);
    chk("wt_same_cycle", rdData, 32'h55);
    tick();
    chk("wt_after", rdData, 32'h55);

    // r0 writes discarded
    issue(6'h06, 5'd0, 5'd0, 32'd9); tick();
    regEn = 1'b0;
    peek(5'd0);
    chk("r0_during", rdData, 32'd0);
    tick();
    chk("r0_after", rdData, 32'd0);

    // Illegal opcode
    issue(6'h3F, 5'd1, 5'd2, 32'd0); tick();
    regEn = 1'b0;
    chk("ill_early", 32'(illegal), 32'd0);
    tick();
    chk("ill_pulse", 32'(illegal), 32'd1);
    chk("ill_rv", 32'(resValid), 32'd0);
    chk("ill_zero", 32'(zero), 32'd0);
    tick();
    chk("ill_end", 32'(illegal), 32'd0);
    peek(5'd1);
    chk("ill_r1", rdData, 32'd19);

    // MUL r4,r5 with a held LDI behind it
    issue(6'h06, 5'd4, 5'd0, 32'd3); tick();
    issue(6'h06, 5'd5, 5'd0, 32'h10000); tick();
    issue(6'h0A, 5'd4, 5'd5, 32'd0); tick();
    issue(6'h06, 5'd13, 5'd0, 32'h77);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("mul_busy_cycles", 32'(n), 32'd33);
    chk("mul_rv", 32'(resValid), 32'd1);
    chk("mul_res", result, 32'h30000);
    chk("mul_carry_hold", 32'(carry), 32'd1);
    peek(5'd4);
    chk("mul_r4", rdData, 32'h30000);
    peek(5'd13);
    chk("held_not_yet", rdData, 32'd0);
    tick();
    regEn = 1'b0;
    tick();
    chk("held_rv", 32'(resValid), 32'd1);
    chk("held_res", result, 32'h77);

    // Reset 10 cycles into a MUL, with regEn asserted on the reset edge
    issue(6'h0A, 5'd5, 5'd4, 32'd0); tick();
    regEn = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("mul_midway_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    issue(6'h06, 5'd15, 5'd0, 32'hAB); tick();
    reset = 1'b0; regEn = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rv", 32'(resValid), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_carry", 32'(carry), 32'd0);
    tick();
    chk("abort_rv2", 32'(resValid), 32'd0);
    flag = 1'b0;
    for (int r = 1; r < 32; r++) begin
      peek(5'(r));
      if (rdData !== 32'd0) flag = 1'b1;
    end
    chk("abort_regs_zero", 32'(flag), 32'd0);
    flag = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (resValid !== 1'b0 || busy !== 1'b0) flag = 1'b1;
    end
    chk("abort_no_late_wb", 32'(flag), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
